// File: rtl/tone_capture_pkg.sv
// Shared register map, bit positions and FSM state type for the tone_capture peripheral.
package tone_capture_pkg;

    localparam int unsigned CTRL_OFS    = 32'h00;
    localparam int unsigned STATUS_OFS  = 32'h04;
    localparam int unsigned HIGH_OFS    = 32'h08;
    localparam int unsigned PERIOD_OFS  = 32'h0C;
    localparam int unsigned EDGE_OFS    = 32'h10;
    localparam int unsigned TIMEOUT_OFS = 32'h14;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_ONESHOT = 1;
    localparam int unsigned CTRL_IE      = 2;

    localparam int unsigned STAT_VALID = 0;
    localparam int unsigned STAT_OVF   = 1;
    localparam int unsigned STAT_BUSY  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StWaitRise,
        StMeasHigh,
        StMeasLow
    } state_e;

endpackage

// File: rtl/tone_capture_pin_sync.sv
// Two-flop synchronizer for the capture pin plus a third flop for rise/fall detection.
module pin_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/tone_capture.sv
// Input-capture peripheral: measures high time and period of a pin in clk cycles,
// counts rising edges and exposes results through a simple register interface.
module tone_capture
    import tone_capture_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 8,
    parameter int unsigned CNTWIDTH  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr,
    input  logic [ADDRWIDTH-1:0] i_waddr,
    input  logic [31:0]          i_wdata,
    input  logic                 i_rd,
    input  logic [ADDRWIDTH-1:0] i_raddr,
    output logic [31:0]          o_rdata,
    input  logic                 i_cap_pin,
    output logic                 o_irq
);

    localparam logic [ADDRWIDTH-1:0] A_CTRL    = ADDRWIDTH'(CTRL_OFS);
    localparam logic [ADDRWIDTH-1:0] A_STATUS  = ADDRWIDTH'(STATUS_OFS);
    localparam logic [ADDRWIDTH-1:0] A_HIGH    = ADDRWIDTH'(HIGH_OFS);
    localparam logic [ADDRWIDTH-1:0] A_PERIOD  = ADDRWIDTH'(PERIOD_OFS);
    localparam logic [ADDRWIDTH-1:0] A_EDGE    = ADDRWIDTH'(EDGE_OFS);
    localparam logic [ADDRWIDTH-1:0] A_TIMEOUT = ADDRWIDTH'(TIMEOUT_OFS);

    logic                r_en;
    logic                r_oneshot;
    logic                r_ie;
    logic                r_valid;
    logic                r_ovf;
    logic [CNTWIDTH-1:0] r_timeout;
    logic [CNTWIDTH-1:0] r_high;
    logic [CNTWIDTH-1:0] r_period;
    logic [CNTWIDTH-1:0] r_edge_cnt;
    logic [CNTWIDTH-1:0] r_cnt;
    logic [31:0]         r_rdata;
    state_e              r_state;

    state_e              w_state_d;
    logic [CNTWIDTH-1:0] w_cnt_d;
    logic [CNTWIDTH-1:0] w_high_d;
    logic [CNTWIDTH-1:0] w_period_d;
    logic [CNTWIDTH-1:0] w_cnt_inc;
    logic                w_valid_set;
    logic                w_ovf_set;
    logic                w_en_clr;
    logic                w_cnt_sat;
    logic                w_timeout_hit;
    logic                w_level;
    logic                w_rise;
    logic                w_fall;
    logic                w_unused_level;
    logic                w_wr_ctrl;
    logic                w_wr_status;
    logic                w_wr_timeout;
    logic                w_busy;
    logic [31:0]         w_rd_data;

    pin_sync_edge u_pin_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pin   (i_cap_pin),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Edges carry all the timing information; the level itself is not needed here.
    assign w_unused_level = w_level;

    assign w_wr_ctrl     = i_wr && (i_waddr == A_CTRL);
    assign w_wr_status   = i_wr && (i_waddr == A_STATUS);
    assign w_wr_timeout  = i_wr && (i_waddr == A_TIMEOUT);
    assign w_busy        = (r_state != StIdle);
    assign w_cnt_sat     = &r_cnt;
    assign w_cnt_inc     = w_cnt_sat ? r_cnt : r_cnt + CNTWIDTH'(1);
    assign w_timeout_hit = (r_timeout != '0) && (r_cnt == r_timeout);

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_high_d    = r_high;
        w_period_d  = r_period;
        w_valid_set = 1'b0;
        w_ovf_set   = 1'b0;
        w_en_clr    = 1'b0;
        if (!r_en) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_d = StWaitRise;
                end
                StWaitRise: begin
                    if (w_rise) begin
                        w_state_d = StMeasHigh;
                        w_cnt_d   = CNTWIDTH'(1);
                    end
                end
                StMeasHigh: begin
                    if (w_timeout_hit || w_cnt_sat) begin
                        w_ovf_set = 1'b1;
                        w_state_d = StWaitRise;
                    end else if (w_fall) begin
                        w_high_d  = r_cnt;
                        w_cnt_d   = w_cnt_inc;
                        w_state_d = StMeasLow;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                StMeasLow: begin
                    if (w_timeout_hit || w_cnt_sat) begin
                        w_ovf_set = 1'b1;
                        w_state_d = StWaitRise;
                    end else if (w_rise) begin
                        w_period_d  = r_cnt;
                        w_valid_set = 1'b1;
                        if (r_oneshot) begin
                            w_state_d = StIdle;
                            w_en_clr  = 1'b1;
                        end else begin
                            w_state_d = StMeasHigh;
                            w_cnt_d   = CNTWIDTH'(1);
                        end
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (i_raddr)
            A_CTRL: begin
                w_rd_data[CTRL_EN]      = r_en;
                w_rd_data[CTRL_ONESHOT] = r_oneshot;
                w_rd_data[CTRL_IE]      = r_ie;
            end
            A_STATUS: begin
                w_rd_data[STAT_VALID] = r_valid;
                w_rd_data[STAT_OVF]   = r_ovf;
                w_rd_data[STAT_BUSY]  = w_busy;
            end
            A_HIGH:    w_rd_data = 32'(r_high);
            A_PERIOD:  w_rd_data = 32'(r_period);
            A_EDGE:    w_rd_data = 32'(r_edge_cnt);
            A_TIMEOUT: w_rd_data = 32'(r_timeout);
            default:   w_rd_data = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_high     <= '0;
            r_period   <= '0;
            r_en       <= 1'b0;
            r_oneshot  <= 1'b0;
            r_ie       <= 1'b0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_timeout  <= '0;
            r_edge_cnt <= '0;
            r_rdata    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_high   <= w_high_d;
            r_period <= w_period_d;

            // A CPU write to CTRL overrides the one-shot auto-clear of EN.
            if (w_wr_ctrl) begin
                r_en      <= i_wdata[CTRL_EN];
                r_oneshot <= i_wdata[CTRL_ONESHOT];
                r_ie      <= i_wdata[CTRL_IE];
            end else if (w_en_clr) begin
                r_en <= 1'b0;
            end

            // New events win over a simultaneous write-1-to-clear.
            r_valid <= w_valid_set | (r_valid & ~(w_wr_status & i_wdata[STAT_VALID]));
            r_ovf   <= w_ovf_set | (r_ovf & ~(w_wr_status & i_wdata[STAT_OVF]));

            if (w_wr_timeout) begin
                r_timeout <= i_wdata[CNTWIDTH-1:0];
            end

            if (w_wr_ctrl && i_wdata[CTRL_EN] && !r_en) begin
                r_edge_cnt <= '0;
            end else if (r_en && w_rise && !(&r_edge_cnt)) begin
                r_edge_cnt <= r_edge_cnt + CNTWIDTH'(1);
            end

            if (i_rd) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_irq   = r_valid & r_ie;

endmodule

// File: tb/tb_tone_capture.sv
// Scoreboard bench for tone_capture: expected reads and measurements are queued when driven.
module tb_tone_capture;
    import tone_capture_pkg::*;

    logic        clk;
    logic        rst;
    logic        wr;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [7:0]  raddr;
    logic [31:0] rdata;
    logic        pin;
    logic        irq;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] meas_q[$];

    int          pin_mode = 0;
    int          pin_h    = 1;
    int          pin_l    = 1;
    int          phase    = 0;

    localparam logic [7:0] A_CTRL    = 8'(CTRL_OFS);
    localparam logic [7:0] A_STATUS  = 8'(STATUS_OFS);
    localparam logic [7:0] A_HIGH    = 8'(HIGH_OFS);
    localparam logic [7:0] A_PERIOD  = 8'(PERIOD_OFS);
    localparam logic [7:0] A_EDGE    = 8'(EDGE_OFS);
    localparam logic [7:0] A_TIMEOUT = 8'(TIMEOUT_OFS);

    tone_capture #(
        .ADDRWIDTH (8),
        .CNTWIDTH  (32)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr      (wr),
        .i_waddr   (waddr),
        .i_wdata   (wdata),
        .i_rd      (rd),
        .i_raddr   (raddr),
        .o_rdata   (rdata),
        .i_cap_pin (pin),
        .o_irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin driver: 0 = low, 1 = high, 2 = square wave pin_h high / pin_l low.
    initial begin
        pin = 1'b0;
        forever begin
            @(negedge clk);
            case (pin_mode)
                1: begin pin = 1'b1; phase = 0; end
                2: begin
                    pin   = (phase < pin_h);
                    phase = (phase + 1 == pin_h + pin_l) ? 0 : phase + 1;
                end
                default: begin pin = 1'b0; phase = 0; end
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        rd = 1'b1; raddr = a;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] got;
        exp_q.push_back(exp);
        rd_reg(a, got);
        check_eq(tag, got, exp_q.pop_front());
    endtask

    task automatic start_square(input int h, input int l);
        pin_h = h;
        pin_l = l;
        meas_q.push_back(32'(h));
        meas_q.push_back(32'(h + l));
        pin_mode = 2;
    endtask

    task automatic wait_valid(input string tag);
        logic [31:0] s;
        logic        seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            rd_reg(A_STATUS, s);
            seen = s[STAT_VALID];
        end
        check_eq(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic check_meas(input string tag);
        logic [31:0] got;
        if (meas_q.size() < 2) begin
            check_eq({tag, "_sb"}, 32'(meas_q.size()), 32'd2);
        end else begin
            rd_reg(A_HIGH, got);
            check_eq({tag, "_high"}, got, meas_q.pop_front());
            rd_reg(A_PERIOD, got);
            check_eq({tag, "_period"}, got, meas_q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0;
        waddr = '0; raddr = '0; wdata = '0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a <= 'h18; a += 4) begin
            rd_expect($sformatf("rst_rd_%02h", a), 8'(a), 32'd0);
        end

        // Same-cycle write and read of TIMEOUT returns the old value
        @(negedge clk);
        wr = 1'b1; waddr = A_TIMEOUT; wdata = 32'h55;
        rd = 1'b1; raddr = A_TIMEOUT;
        exp_q.push_back(32'd0);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        check_eq("wr_rd_same", rdata, exp_q.pop_front());
        rd_expect("timeout_rb", A_TIMEOUT, 32'h55);
        wr_reg(A_TIMEOUT, 32'd0);
        wr_reg(A_HIGH, 32'hdead);
        rd_expect("ro_ignored", A_HIGH, 32'd0);
        wr_reg(8'h18, 32'hffff);
        rd_expect("unmapped", 8'h18, 32'd0);

        // Continuous 6/14 measurement with interrupt
        wr_reg(A_CTRL, 32'h5);
        tick(5);
        start_square(6, 14);
        wait_valid("m1_valid");
        pin_mode = 0;
        check_meas("m1");
        check_eq("m1_irq", {31'd0, irq}, 32'd1);
        wr_reg(A_STATUS, 32'h1);
        check_eq("m1_irq_clr", {31'd0, irq}, 32'd0);
        rd_expect("m1_status", A_STATUS, 32'h4);

        // One-shot 3/5
        wr_reg(A_CTRL, 32'h0);
        tick(3);
        wr_reg(A_CTRL, 32'h3);
        tick(5);
        start_square(3, 5);
        wait_valid("os_valid");
        pin_mode = 0;
        check_meas("os");
        rd_expect("os_ctrl", A_CTRL, 32'h2);
        rd_expect("os_status", A_STATUS, 32'h1);
        rd_expect("os_edge", A_EDGE, 32'd2);
        pin_h = 2; pin_l = 2; pin_mode = 2;
        tick(40);
        pin_mode = 0;
        tick(4);
        rd_expect("os_edge_hold", A_EDGE, 32'd2);

        // Timeout on a pin stuck high
        wr_reg(A_STATUS, 32'h3);
        wr_reg(A_TIMEOUT, 32'd10);
        wr_reg(A_CTRL, 32'h1);
        tick(5);
        pin_mode = 1;
        tick(6);
        rd_expect("to_early", A_STATUS, 32'h4);
        tick(20);
        rd_expect("to_ovf", A_STATUS, 32'h6);
        rd_expect("to_high_kept", A_HIGH, 32'd3);
        pin_mode = 0;
        wr_reg(A_TIMEOUT, 32'd0);
        wr_reg(A_STATUS, 32'h2);

        // Edge counting
        wr_reg(A_CTRL, 32'h0);
        tick(3);
        wr_reg(A_CTRL, 32'h1);
        rd_expect("edge_clr0", A_EDGE, 32'd0);
        for (int i = 0; i < 5; i++) begin
            pin_mode = 1; tick(4);
            pin_mode = 0; tick(4);
        end
        tick(4);
        rd_expect("edge_5", A_EDGE, 32'd5);
        wr_reg(A_CTRL, 32'h0);
        rd_expect("edge_kept", A_EDGE, 32'd5);
        rd_expect("en0_idle", A_STATUS, 32'h1);
        wr_reg(A_CTRL, 32'h1);
        rd_expect("edge_clr1", A_EDGE, 32'd0);

        // Reset in the middle of a low phase
        wr_reg(A_STATUS, 32'h1);
        wr_reg(A_CTRL, 32'h5);
        tick(3);
        start_square(6, 14);
        wait_valid("r_valid");
        check_meas("r_pre");
        tick(5);
        @(negedge clk);
        rst = 1'b1; pin_mode = 0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("r_irq", {31'd0, irq}, 32'd0);
        for (int a = 0; a <= 'h14; a += 4) begin
            rd_expect($sformatf("r_rd_%02h", a), 8'(a), 32'd0);
        end
        tick(3);
        wr_reg(A_CTRL, 32'h1);
        tick(5);
        start_square(6, 14);
        wait_valid("r2_valid");
        pin_mode = 0;
        check_meas("r2");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tone_capture.md
# tone_capture

Memory-mapped input-capture peripheral: the receiving counterpart of the buzzer. It samples an external square-wave pin and measures high time and period in `clk` cycles. It counts rising edges and reports results through the same CPU register interface the buzzer uses (`wr`/`waddr`/`wdata`, `rd`/`raddr`/`rdata`). It sits on the CPU peripheral bus beside the buzzer and can loop back the buzzer pin for self-test.

## Interface
- `ADDRWIDTH`, 8: width of `waddr`/`raddr`; only byte offsets 0x00–0x14 are decoded.
- `CNTWIDTH`, 32: width of the measurement counters; the value is zero-extended to 32 bits in `rdata`.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, **synchronous, active-high**.
- `wr` in 1: write strobe, sampled on a `clk` edge.
- `waddr` in `ADDRWIDTH`: write byte offset.
- `wdata` in 32: write data.
- `rd` in 1: read strobe.
- `raddr` in `ADDRWIDTH`: read byte offset.
- `rdata` out 32: registered read data.
- `cap_pin` in 1: asynchronous input pin.
- `irq` out 1: level interrupt, equal to `STATUS.VALID & CTRL.IE`.

## Operation
- Register map:
  - 0x00 CTRL (RW): bit0 EN, bit1 ONESHOT, bit2 IE.
  - 0x04 STATUS: bit0 VALID, bit1 OVF, bit2 BUSY. VALID and OVF are write-1-to-clear; BUSY is read-only.
  - 0x08 HIGH_CNT (RO).
  - 0x0C PERIOD_CNT (RO).
  - 0x10 EDGE_CNT (RO): saturating rising-edge count since EN last went 0→1.
  - 0x14 TIMEOUT (RW, `CNTWIDTH` bits): 0 disables the timeout.
  - Writes to RO or unmapped offsets are ignored. Reads of unmapped offsets return 0.
- Pin path: 2-flop synchronizer, then a third flop for edge detection. `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- FSM states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW. BUSY = (state != IDLE).
  - IDLE → WAIT_RISE when EN=1.
  - WAIT_RISE → MEAS_HIGH on `rise`. `cnt` ← 1.
  - MEAS_HIGH → MEAS_LOW on `fall`. HIGH_CNT ← `cnt`, then `cnt` increments.
  - MEAS_LOW on `rise`: PERIOD_CNT ← `cnt` and VALID ← 1.
    - If ONESHOT=1: go to IDLE and clear CTRL.EN.
    - Otherwise: go to MEAS_HIGH with `cnt` ← 1.
  - In MEAS_HIGH and MEAS_LOW, `cnt` increments each cycle and saturates at all-ones.
- Resulting values: for a steady waveform of H cycles high and L cycles low, HIGH_CNT = H and PERIOD_CNT = H+L exactly.
- Timeout: if TIMEOUT≠0 and `cnt` == TIMEOUT in MEAS_HIGH or MEAS_LOW, then OVF ← 1 and the FSM goes to WAIT_RISE. HIGH_CNT and PERIOD_CNT are unchanged.
- Counter saturation: if `cnt` saturates, OVF ← 1 and the FSM goes to WAIT_RISE.
- EDGE_CNT increments on every `rise` while EN=1, and saturates.
- EN written 0: the FSM goes to IDLE on the next cycle. Results and EDGE_CNT are retained.
- EN written 0→1: EDGE_CNT clears to 0.

## Timing
- Reset values: `rdata`=0, `irq`=0, all registers 0, FSM in IDLE, synchronizer flops 0.
- Pin edge detection: `rise`/`fall` is asserted in the 3rd `clk` cycle after the pin change is first sampled. Latency is constant, so measurements are unaffected.
- Write: a register updates on the `clk` edge where `wr`=1, and is visible the next cycle.
- Read: `rdata` is loaded on the edge where `rd`=1 and holds until the next `rd`. Reading has no side effects.
- Simultaneous events:
  - W1C of VALID in the same cycle as a new measurement: set wins, VALID=1.
  - W1C of OVF in the same cycle as a new overflow: set wins.
  - Write of CTRL in the same cycle as the ONESHOT auto-clear of EN: the CPU write wins.
  - `wr` and `rd` to the same offset in one cycle: `rdata` returns the old value.
- `irq` is registered-path: it follows VALID with 0 extra cycles, since it is computed from registered bits.
- `rst` mid-measurement: everything returns to reset values on that edge, and no partial result is latched.

## Structure
- Package `tone_capture_pkg`:
  - register offset constants (`CTRL_OFS`…`TIMEOUT_OFS`)
  - CTRL/STATUS bit indices
  - FSM state enum type
- Sub-module `pin_sync_edge`: synchronizer plus edge detector; outputs `level`, `rise`, `fall`, and has a reset input.
- Top level: register file, FSM, counters, read mux.

## Test plan
- Reset then read every offset: all return 0, and `irq`=0.
- EN=1, IE=1; pin drives 6 high / 14 low repeatedly: after the second rise, HIGH_CNT=6, PERIOD_CNT=20, VALID=1, `irq`=1. Write STATUS=0x1: VALID=0 and `irq`=0 on the next cycle.
- CTRL=0x3 (ONESHOT); pin drives 3 high / 5 low: exactly one result (3, 8), then CTRL.EN reads 0 and BUSY=0. Further edges do not change EDGE_CNT.
- TIMEOUT=10; pin goes high and stays high: OVF=1 after 10 counted cycles, FSM in WAIT_RISE, HIGH_CNT unchanged.
- Toggle the pin for 5 rises with EN=1: EDGE_CNT=5. Write EN 0 then 1: EDGE_CNT=0.
- Assert `rst` during MEAS_LOW: all registers return to 0, and a subsequent EN=1 measures 6/20 correctly.
